// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time writer for the MIPS instruction memory. Accepts a framed byte
// stream on a valid/ready interface, assembles big-endian 32-bit words and
// writes them to consecutive instruction-memory word addresses. The core is
// held in reset until a complete frame passes its checksum.
//
// Frame: 0xA5, LEN_HI, LEN_LO (N words), 4*N data bytes (MSB first), CHK.
// CHK is the modulo-256 sum of the data bytes only.
//
// Ports:
//   CLK         single clock, rising edge
//   RST         asynchronous active-low reset
//   in_valid    byte source has a byte on in_data
//   in_data     stream byte
//   in_ready    loader can accept a byte this cycle (decodes state only)
//   imem_we     one-cycle instruction-memory write strobe (registered)
//   imem_addr   word address for the write, held between writes
//   imem_wdata  word to write, held between writes
//   cpu_rst_n   active-low core reset, released after a good frame
//   load_done   frame loaded and checksum matched (sticky until reset)
//   load_err    frame rejected (sticky until the next sync byte)
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              load_done,
  output logic              load_err
);

  // Word counter needs one extra bit so that N = 2**ADDR_W can be counted
  // without wrapping. Length and counter comparisons are done at 17 bits,
  // which covers the 16-bit length field for any ADDR_W up to 16.
  localparam int          CNT_W     = ADDR_W + 1;
  localparam logic [7:0]  SYNC      = 8'hA5;
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHK,
    S_ERR,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        len_q, len_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [23:0]        shift_q, shift_d;
  logic [7:0]         sum_q, sum_d;

  logic               we_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [31:0]        wdata_d;
  logic               cpu_rst_n_d;
  logic               done_d;
  logic               err_d;

  logic               accept;
  logic [15:0]        len_full;
  logic               last_word;

  // Ready is a pure state decode so there is no combinational path from
  // in_valid back to in_ready.
  assign in_ready = (state_q != S_DONE);
  assign accept   = in_valid & in_ready;

  // Complete length as seen while the LEN_LO byte is on the bus.
  assign len_full  = {len_q[15:8], in_data};

  // True while the current word is the final one of the frame.
  assign last_word = ((17'(word_cnt_q) + 17'd1) == {1'b0, len_q});

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    byte_idx_d  = byte_idx_q;
    shift_d     = shift_q;
    sum_d       = sum_q;
    we_d        = 1'b0;
    addr_d      = imem_addr;
    wdata_d     = imem_wdata;
    cpu_rst_n_d = cpu_rst_n;
    done_d      = load_done;
    err_d       = load_err;

    if (accept) begin
      unique case (state_q)
        S_IDLE, S_ERR: begin
          // Hunt for sync; a new frame starts from a clean sum and counter.
          if (in_data == SYNC) begin
            state_d    = S_LEN_HI;
            err_d      = 1'b0;
            sum_d      = 8'h00;
            word_cnt_d = '0;
            byte_idx_d = 2'd0;
          end
        end

        S_LEN_HI: begin
          len_d   = {in_data, 8'h00};
          state_d = S_LEN_LO;
        end

        S_LEN_LO: begin
          len_d = len_full;
          if (len_full == 16'h0000) begin
            state_d = S_CHK;
          end else if ({1'b0, len_full} > MAX_WORDS) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end

        S_DATA: begin
          sum_d      = sum_q + in_data;
          shift_d    = {shift_q[15:0], in_data};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            we_d       = 1'b1;
            addr_d     = word_cnt_q[ADDR_W-1:0];
            wdata_d    = {shift_q, in_data};
            word_cnt_d = word_cnt_q + CNT_W'(1);
            if (last_word) begin
              state_d = S_CHK;
            end
          end
        end

        S_CHK: begin
          if (in_data == sum_q) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            cpu_rst_n_d = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end

        S_DONE: begin
          // Terminal; in_ready is low so no byte is ever accepted here.
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      len_q      <= 16'h0000;
      word_cnt_q <= '0;
      byte_idx_q <= 2'd0;
      shift_q    <= 24'h000000;
      sum_q      <= 8'h00;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0000_0000;
      cpu_rst_n  <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here sample the
      // pre-edge values, independent of statement order.
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      sum_q      <= sum_d;
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      cpu_rst_n  <= cpu_rst_n_d;
      load_done  <= done_d;
      load_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader (ADDR_W = 8). A table of whole frames
// with constant expectations, hand-written sequences for cycle-level corners
// (write strobe timing, completion timing, reset mid-word, post-DONE bytes),
// and randomized frames with in_valid gaps checked against a frame-parsing
// reference model that works directly on the byte list.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              CLK;
  logic              RST;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst_n;
  logic              load_done;
  logic              load_err;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [127:0] frame;     // bytes right-aligned, first byte most significant
    int           nbytes;
    bit           done;
    bit           err;
    int           nwr;
    logic [31:0]  last_data;
  } vec_t;

  int         checks   = 0;
  int         failures = 0;
  wr_t        got[$];
  wr_t        exp_wr[$];
  logic [7:0] stream[$];
  bit         exp_done;
  bit         exp_err;
  logic       prev_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: records every strobe and checks strobes never overlap.
  always @(negedge CLK) begin
    if (imem_we === 1'b1) begin
      got.push_back('{addr: imem_addr, data: imem_wdata});
      check("we_single_cycle", {31'd0, prev_we}, 32'd0);
    end
    prev_we = imem_we;
  end

  // Reference model: parse the byte list by the frame rules and list the
  // writes and final status the loader must produce.
  task automatic run_model();
    int         i;
    int         n;
    logic [7:0] sum;
    logic [31:0] w;
    exp_wr.delete();
    exp_done = 0;
    exp_err  = 0;
    i = 0;
    while (i < stream.size() && !exp_done) begin
      if (stream[i] != 8'hA5) begin
        i++;
        continue;
      end
      exp_err = 0;
      i++;
      if (i + 2 > stream.size()) return;
      n = int'({stream[i], stream[i+1]});
      i += 2;
      if (n > DEPTH) begin
        exp_err = 1;
        continue;
      end
      sum = 8'h00;
      for (int k = 0; k < n; k++) begin
        if (i + 4 > stream.size()) return;
        w   = {stream[i], stream[i+1], stream[i+2], stream[i+3]};
        sum = sum + stream[i] + stream[i+1] + stream[i+2] + stream[i+3];
        exp_wr.push_back('{addr: 8'(k), data: w});
        i += 4;
      end
      if (i >= stream.size()) return;
      if (stream[i] == sum) exp_done = 1;
      else                  exp_err  = 1;
      i++;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    in_valid = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    got.delete();
  endtask

  // Offer one byte after 'gap' idle cycles; give up after a bounded wait.
  task automatic send_byte(input logic [7:0] b, input int gap, output bit acc);
    in_valid = 1'b0;
    repeat (gap) @(negedge CLK);
    in_valid = 1'b1;
    in_data  = b;
    acc      = 0;
    for (int t = 0; t < 16 && !acc; t++) begin
      if (in_ready) acc = 1;
      @(negedge CLK);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_stream(input int max_gap, input string tag);
    bit acc;
    int n_acc;
    n_acc = 0;
    for (int i = 0; i < stream.size(); i++) begin
      send_byte(stream[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)), acc);
      if (acc) n_acc++;
    end
    check({tag, "_accepted"}, 32'(n_acc), 32'(stream.size()));
  endtask

  task automatic send_one(input logic [7:0] b);
    bit acc;
    send_byte(b, 0, acc);
    check("byte_accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic compare_all(input string tag);
    #1;
    check({tag, "_nwr"}, 32'(got.size()), 32'(exp_wr.size()));
    for (int k = 0; k < exp_wr.size() && k < got.size(); k++) begin
      check({tag, "_addr"}, 32'(got[k].addr), 32'(exp_wr[k].addr));
      check({tag, "_data"}, got[k].data, exp_wr[k].data);
    end
    check({tag, "_done"},      {31'd0, load_done}, {31'd0, exp_done});
    check({tag, "_err"},       {31'd0, load_err},  {31'd0, exp_err});
    check({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, {31'd0, exp_done});
    check({tag, "_in_ready"},  {31'd0, in_ready},  {31'd0, !exp_done});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},   {31'd0, in_ready},  32'd1);
    check({tag, "_imem_we"},    {31'd0, imem_we},   32'd0);
    check({tag, "_imem_addr"},  32'(imem_addr),     32'd0);
    check({tag, "_imem_wdata"}, imem_wdata,         32'd0);
    check({tag, "_cpu_rst_n"},  {31'd0, cpu_rst_n}, 32'd0);
    check({tag, "_load_done"},  {31'd0, load_done}, 32'd0);
    check({tag, "_load_err"},   {31'd0, load_err},  32'd0);
  endtask

  task automatic push_good_frame();
    logic [7:0] good [12];
    good = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
             8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h38};
    for (int i = 0; i < 12; i++) stream.push_back(good[i]);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t       vecs[$];
    bit         acc;
    logic [7:0] b;
    logic [7:0] sum;
    int         n;

    RST      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #3;
    check_reset_values("por");
    @(negedge CLK);
    RST = 1'b1;

    // ---------------- table-driven whole-frame vectors ----------------
    vecs.push_back('{128'hA5_0002_12345678_9ABCDEF0_38,        12, 1, 0, 2, 32'h9ABCDEF0});
    vecs.push_back('{128'hA5_0002_12345678_9ABCDEF0_39,        12, 0, 1, 2, 32'h9ABCDEF0});
    vecs.push_back('{128'h00FF5A_A5_0002_12345678_9ABCDEF0_38, 15, 1, 0, 2, 32'h9ABCDEF0});
    vecs.push_back('{128'hA5_0000_00,                           4, 1, 0, 0, 32'h0});
    vecs.push_back('{128'hA5_0101,                              3, 0, 1, 0, 32'h0});
    vecs.push_back('{128'hA5_FFFF,                              3, 0, 1, 0, 32'h0});
    vecs.push_back('{128'hA5_0001_A5A5A5A5_94,                  8, 1, 0, 1, 32'hA5A5A5A5});

    for (int v = 0; v < vecs.size(); v++) begin
      do_reset();
      stream.delete();
      for (int i = 0; i < vecs[v].nbytes; i++) begin
        b = vecs[v].frame[8*(vecs[v].nbytes-1-i) +: 8];
        stream.push_back(b);
      end
      send_stream(0, $sformatf("vec%0d", v));
      #1;
      check($sformatf("vec%0d_done", v),      {31'd0, load_done}, {31'd0, vecs[v].done});
      check($sformatf("vec%0d_err", v),       {31'd0, load_err},  {31'd0, vecs[v].err});
      check($sformatf("vec%0d_cpu_rst_n", v), {31'd0, cpu_rst_n}, {31'd0, vecs[v].done});
      check($sformatf("vec%0d_in_ready", v),  {31'd0, in_ready},  {31'd0, !vecs[v].done});
      check($sformatf("vec%0d_nwr", v),       32'(got.size()),    32'(vecs[v].nwr));
      if (vecs[v].nwr > 0 && got.size() > 0) begin
        check($sformatf("vec%0d_last_data", v), got[got.size()-1].data, vecs[v].last_data);
        check($sformatf("vec%0d_last_addr", v), 32'(got[got.size()-1].addr), 32'(vecs[v].nwr - 1));
      end
    end

    // ---------------- cycle-level timing of a good load ----------------
    do_reset();
    send_one(8'hA5); send_one(8'h00); send_one(8'h02);
    send_one(8'h12); send_one(8'h34); send_one(8'h56);
    check("pre_word_we", {31'd0, imem_we}, 32'd0);
    send_one(8'h78);
    check("w0_we",    {31'd0, imem_we}, 32'd1);
    check("w0_addr",  32'(imem_addr),   32'd0);
    check("w0_wdata", imem_wdata,       32'h12345678);
    send_one(8'h9A);
    check("hold_we",    {31'd0, imem_we}, 32'd0);
    check("hold_addr",  32'(imem_addr),   32'd0);
    check("hold_wdata", imem_wdata,       32'h12345678);
    send_one(8'hBC); send_one(8'hDE);
    check("w1_pre_we", {31'd0, imem_we}, 32'd0);
    send_one(8'hF0);
    check("w1_we",    {31'd0, imem_we}, 32'd1);
    check("w1_addr",  32'(imem_addr),   32'd1);
    check("w1_wdata", imem_wdata,       32'h9ABCDEF0);
    check("pre_chk_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    send_one(8'h38);
    check("done_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    check("done_load_done", {31'd0, load_done}, 32'd1);
    check("done_in_ready",  {31'd0, in_ready},  32'd0);
    check("done_we",        {31'd0, imem_we},   32'd0);
    check("done_addr_held", 32'(imem_addr),     32'd1);
    send_byte(8'hA5, 0, acc);
    check("after_done_not_accepted", {31'd0, acc}, 32'd0);
    check("after_done_still_done",   {31'd0, load_done}, 32'd1);
    check("after_done_nwr",          32'(got.size()), 32'd2);

    // ---------------- bad checksum, then resend ----------------
    do_reset();
    stream.delete();
    push_good_frame();
    stream[11] = 8'h39;
    send_stream(0, "bad");
    check("bad_err",       {31'd0, load_err},  32'd1);
    check("bad_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    send_one(8'hA5);
    check("resend_err_cleared", {31'd0, load_err}, 32'd0);
    for (int i = 1; i < 12; i++) begin
      stream.push_back(8'h00);
    end
    // Rebuild the full stream (bad frame + good frame) for the model.
    stream.delete();
    push_good_frame();
    stream[11] = 8'h39;
    push_good_frame();
    for (int i = 13; i < 24; i++) send_one(stream[i]);
    run_model();
    compare_all("resend");

    // ---------------- maximum length: 2**ADDR_W words ----------------
    do_reset();
    stream.delete();
    stream.push_back(8'hA5);
    stream.push_back(8'h01);
    stream.push_back(8'h00);
    sum = 8'h00;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      b = 8'($urandom);
      stream.push_back(b);
      sum = sum + b;
    end
    stream.push_back(sum);
    send_stream(0, "max");
    run_model();
    compare_all("max");
    if (got.size() > 0) check("max_last_addr", 32'(got[got.size()-1].addr), 32'hFF);

    // ---------------- random frames with in_valid gaps ----------------
    for (int r = 0; r < 12; r++) begin
      do_reset();
      stream.delete();
      n = int'($urandom_range(0, 3));
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        stream.push_back(b);
      end
      n = int'($urandom_range(0, 6));
      stream.push_back(8'hA5);
      stream.push_back(8'(n >> 8));
      stream.push_back(8'(n));
      sum = 8'h00;
      for (int j = 0; j < 4 * n; j++) begin
        b = 8'($urandom);
        stream.push_back(b);
        sum = sum + b;
      end
      if ($urandom_range(0, 3) == 0) sum = sum + 8'd1;
      stream.push_back(sum);
      send_stream(5, $sformatf("rand%0d", r));
      run_model();
      compare_all($sformatf("rand%0d", r));
    end

    // ---------------- reset in the middle of a word ----------------
    do_reset();
    send_one(8'hA5); send_one(8'h00); send_one(8'h02);
    send_one(8'h12); send_one(8'h34);
    #2;
    RST = 1'b0;
    #1;
    check_reset_values("midword_rst");
    @(negedge CLK);
    RST = 1'b1;
    check("midword_no_write", 32'(got.size()), 32'd0);
    stream.delete();
    push_good_frame();
    send_stream(2, "after_rst");
    run_model();
    compare_all("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the MIPS instruction memory. Receives a framed byte stream over a valid/ready interface, assembles big-endian 32-bit words and writes them into consecutive instruction-memory word addresses. Holds the processor core in reset until a complete frame passes its checksum, then releases the core. Sits between the host/debug byte source and the instruction-memory write port, beside MIPS_TOP.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity is 2**ADDR_W words.
- CLK  input  1  single clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- in_valid  input  1  byte source has a byte on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  32  word to write.
- cpu_rst_n  output  1  active-low reset to the core; low until load succeeds.
- load_done  output  1  frame loaded and checksum matched (sticky).
- load_err  output  1  frame rejected (sticky until next sync byte).

## Operation
- Frame: sync 0xA5, LEN_HI, LEN_LO (N words, 16-bit), 4*N data bytes (each word MSB first), CHK.
- CHK = 8-bit modulo-256 sum of data bytes only; sync and length bytes are excluded.
- A byte is accepted on a rising edge with in_valid=1 and in_ready=1; nothing else advances state.
- States and transitions (taken on acceptance):
  - IDLE: 0xA5 -> LEN_HI; any other byte discarded.
  - LEN_HI -> LEN_LO.
  - LEN_LO: N=0 -> CHK; N>2**ADDR_W -> ERR; else -> DATA.
  - DATA: shift byte into word, add to sum; 4th byte of word issues write; after last byte of word N-1 -> CHK.
  - CHK: match -> DONE; mismatch -> ERR.
  - ERR: 0xA5 -> LEN_HI (clears load_err, sum, word counter); other bytes discarded.
  - DONE: terminal until RST.
- in_ready = 1 in every state except DONE.
- Word counter is ADDR_W+1 bits wide; imem_addr = counter[ADDR_W-1:0]; N=2**ADDR_W fills memory exactly, no wrap.
- Words already written on a rejected frame stay in memory; the core is not released.
- imem_addr and imem_wdata hold their last values when imem_we=0.

## Timing
- Reset (RST low, immediate): state IDLE, in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst_n=0, load_done=0, load_err=0, sum=0, counter=0.
- Reset mid-frame aborts the frame; memory contents are not cleared.
- imem_we is registered: high for exactly the cycle after the edge accepting a word's 4th byte, with imem_addr/imem_wdata valid in that same cycle.
- Back-to-back bytes give at most one write every 4 cycles; no write-strobe overlap is possible.
- Good CHK: cpu_rst_n, load_done rise together one cycle after the accepting edge (registered), in_ready falls in that same cycle.
- Bad CHK or oversize N: load_err rises one cycle after the accepting edge.
- Gaps on in_valid stall the FSM with no other effect; any gap length is legal.
- All outputs are registered except in_ready, which decodes state only (no in_valid path).

## Test plan
- Good load: A5 00 02 12 34 56 78 9A BC DE F0 38 back-to-back -> writes addr0=0x12345678, addr1=0x9ABCDEF0, one imem_we cycle each; then cpu_rst_n=1, load_done=1, in_ready=0.
- Bad checksum: same frame with CHK 0x39 -> load_err=1, cpu_rst_n=0; then resend good frame -> load_err clears on A5, ends with load_done=1.
- Sync hunt: 00 FF 5A then good frame -> leading bytes ignored, result as in the good-load case.
- Length bounds (ADDR_W=8): A5 00 00 00 -> load_done=1, no writes; A5 01 01 -> load_err=1; A5 01 00 plus 1024 bytes and correct CHK -> 256 writes, last addr 0xFF.
- Flow control: good frame with random 0-5 cycle in_valid gaps -> identical writes and completion; bytes offered after DONE are not accepted.
- Reset mid-word: assert RST after 2 data bytes -> all outputs return to reset values immediately; a following good frame loads correctly.
